// File: rtl/shift_ex_stage.sv
// Execute-stage shifter (SLL/SRA/ROR/PASS) with a two-entry result buffer.
// in_ready depends only on registered state, so out_ready never reaches it combinationally.
module shift_ex_stage #(
  parameter bit FLAGS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [15:0] src,
  input  logic [3:0]  amt,
  input  logic [3:0]  dst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_dst,
  output logic        out_z,
  output logic        out_n
);

  localparam logic [1:0] OpSll  = 2'b00;
  localparam logic [1:0] OpSra  = 2'b01;
  localparam logic [1:0] OpRor  = 2'b10;
  localparam logic [1:0] OpPass = 2'b11;

  typedef struct packed {
    logic [15:0] result;
    logic [3:0]  dst;
    logic        z;
    logic        n;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   capture, pop;

  logic [15:0] shift_res;
  logic [31:0] rot_src;
  logic [31:0] rot_shifted;

  assign rot_src     = {src, src};
  assign rot_shifted = rot_src >> amt;

  always_comb begin
    shift_res = src;
    case (op)
      OpSll:   shift_res = src << amt;
      OpSra:   shift_res = $unsigned($signed(src) >>> amt);
      OpRor:   shift_res = rot_shifted[15:0];
      OpPass:  shift_res = src;
      default: shift_res = src;
    endcase
  end

  always_comb begin
    new_entry.result = shift_res;
    new_entry.dst    = dst;
    new_entry.z      = FLAGS_EN ? (shift_res == 16'h0000) : 1'b0;
    new_entry.n      = FLAGS_EN ? shift_res[15] : 1'b0;
  end

  assign in_ready = !skid_valid_q;
  assign capture  = in_valid && in_ready && !flush;
  assign pop      = main_valid_q && out_ready;

  // Skid can only be occupied while main is occupied, so main empty implies skid empty.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = capture;
        if (capture) skid_d = new_entry;
      end else begin
        main_valid_d = capture;
        if (capture) main_d = new_entry;
      end
    end else if (!main_valid_q) begin
      main_valid_d = capture;
      if (capture) main_d = new_entry;
    end else if (capture) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_result = main_q.result;
  assign out_dst    = main_q.dst;
  assign out_z      = main_q.z;
  assign out_n      = main_q.n;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed-vector and random-scoreboard bench for shift_ex_stage.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [15:0] src = 16'h0000;
  logic [3:0]  amt = 4'h0;
  logic [3:0]  dst = 4'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_z;
  logic        out_n;

  int errors = 0;
  int checks = 0;

  shift_ex_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src        (src),
    .amt        (amt),
    .dst        (dst),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_z      (out_z),
    .out_n      (out_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] src;
    logic [3:0]  amt;
    logic [3:0]  dst;
    logic [15:0] res;
    logic        z;
    logic        n;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  dst;
    logic        z;
    logic        n;
  } exp_t;

  vec_t vecs[12];
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] o, input logic [15:0] s,
                       input logic [3:0] a, input logic [3:0] d);
    in_valid = v;
    op       = o;
    src      = s;
    amt      = a;
    dst      = d;
  endtask

  // Bit-by-bit reference, deliberately unlike the RTL's shift operators.
  function automatic exp_t model(input logic [1:0] o, input logic [15:0] s,
                                 input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    int   k;
    for (int i = 0; i < 16; i++) begin
      k = i + int'(a);
      case (o)
        2'b00:   e.res[i] = (i >= int'(a)) ? s[i - int'(a)] : 1'b0;
        2'b01:   e.res[i] = (k <= 15) ? s[k] : s[15];
        2'b10:   e.res[i] = s[k % 16];
        default: e.res[i] = s[i];
      endcase
    end
    e.dst = d;
    e.z   = (e.res == 16'h0000);
    e.n   = e.res[15];
    return e;
  endfunction

  initial begin
    exp_t e, front;
    logic stall_prev;
    logic [23:0] held;
    int pushed;

    vecs[0]  = '{2'b10, 16'h8001, 4'd1,  4'd3,  16'hC000, 1'b0, 1'b1};
    vecs[1]  = '{2'b01, 16'h8000, 4'd15, 4'd1,  16'hFFFF, 1'b0, 1'b1};
    vecs[2]  = '{2'b00, 16'h0001, 4'd15, 4'd2,  16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 16'h8000, 4'd1,  4'd4,  16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 16'h1234, 4'd5,  4'd5,  16'h1234, 1'b0, 1'b0};
    vecs[5]  = '{2'b00, 16'h00F0, 4'd0,  4'd6,  16'h00F0, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 16'h7FF0, 4'd4,  4'd7,  16'h07FF, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 16'h1234, 4'd4,  4'd8,  16'h4123, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 16'h8421, 4'd0,  4'd9,  16'h8421, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 16'h0000, 4'd7,  4'd10, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{2'b00, 16'h1234, 4'd4,  4'd11, 16'h2340, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 16'hF0F0, 4'd8,  4'd15, 16'hFFF0, 1'b0, 1'b1};

    // Reset state
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset outputs", {out_result, out_dst, out_z, out_n}, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    #10;
    rst_n = 1'b1;

    // Back-to-back table vectors with out_ready high: one per cycle, latency 1
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].src, vecs[i].amt, vecs[i].dst);
      step();
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d result", i), 32'(out_result), 32'(vecs[i].res));
      chk($sformatf("vec%0d dst", i), 32'(out_dst), 32'(vecs[i].dst));
      chk($sformatf("vec%0d zn", i), {30'd0, out_z, out_n}, {30'd0, vecs[i].z, vecs[i].n});
    end
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    step();
    chk("drain valid", 32'(out_valid), 32'd0);

    // Stall: A and B accepted, C held off until out_ready rises
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 16'hAAAA, 4'd0, 4'd1);
    step();
    chk("stall A shown", 32'(out_result), 32'h0000AAAA);
    chk("stall ready after A", 32'(in_ready), 32'd1);
    drive(1'b1, 2'b11, 16'hBBBB, 4'd0, 4'd2);
    step();
    chk("stall ready after B", 32'(in_ready), 32'd0);
    drive(1'b1, 2'b11, 16'hCCCC, 4'd0, 4'd3);
    step();
    chk("stall A held", {out_result, out_dst}, {12'd0, 16'hAAAA, 4'd1});
    chk("stall C blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("emit B", {out_valid, out_result, out_dst}, {11'd0, 1'b1, 16'hBBBB, 4'd2});
    step();
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    chk("emit C", {out_valid, out_result, out_dst}, {11'd0, 1'b1, 16'hCCCC, 4'd3});
    step();
    chk("after C empty", 32'(out_valid), 32'd0);

    // Flush with both entries full and a valid input
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 16'h1111, 4'd0, 4'd1);
    step();
    drive(1'b1, 2'b11, 16'h2222, 4'd0, 4'd2);
    step();
    chk("full before flush", 32'(in_ready), 32'd0);
    drive(1'b1, 2'b11, 16'h3333, 4'd0, 4'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flushed op absent", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset mid-cycle while streaming
    drive(1'b1, 2'b00, 16'h00FF, 4'd4, 4'd9);
    step();
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(out_valid), 32'd0);
    chk("async reset outputs", {out_result, out_dst, out_z, out_n}, 32'd0);
    chk("async reset in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    step();
    chk("held reset valid", 32'(out_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 2'b10, 16'h0003, 4'd1, 4'd12);
    step();
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    chk("post-reset latency", {out_valid, out_result, out_dst, out_n},
        {10'd0, 1'b1, 16'h8001, 4'd12, 1'b1});
    step();
    chk("post-reset empty", 32'(out_valid), 32'd0);

    // Random stream against the reference model with random backpressure
    pushed = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 8000 && (pushed < 1000 || q.size() != 0); cyc++) begin
      if (stall_prev) chk("stall stable", 32'({out_result, out_dst, out_z, out_n}), 32'(held));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected output", 32'(out_valid), 32'd0);
        end else begin
          front = q[0];
          chk("rand output", {out_result, out_dst, out_z, out_n},
              {10'd0, front.res, front.dst, front.z, front.n});
        end
      end
      drive((pushed < 1000) && ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(op, src, amt, dst);
        q.push_back(e);
        pushed++;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_result, out_dst, out_z, out_n};
      step();
    end
    chk("rand all accepted", 32'(pushed), 32'd1000);
    chk("rand queue drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_ex_stage.md
SHIFT_EX_STAGE -- requirements
Module: shift_ex_stage

Interface
REQ-001 SHALL have parameter FLAGS_EN, default 1, meaning: 1 computes Z/N flags; 0 forces out_z and out_n to 0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream (ID/EX) presents an operation.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port op  input  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 PASS.
REQ-007 SHALL have port src  input  16  operand.
REQ-008 SHALL have port amt  input  4  shift/rotate amount, 0..15.
REQ-009 SHALL have port dst  input  4  destination register tag, carried unchanged.
REQ-010 SHALL have port flush  input  1  discard all held and incoming operations.
REQ-011 SHALL have port out_valid  output  1  a result is presented to EX/MEM.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-013 SHALL have port out_result  output  16  shifted/rotated result.
REQ-014 SHALL have port out_dst  output  4  tag of the presented result.
REQ-015 SHALL have ports out_z and out_n  output  1 each  result zero flag and result bit-15 flag.

Function
REQ-016 SHALL compute SLL as src shifted left by amt with zero fill.
REQ-017 SHALL compute SRA as src shifted right by amt with src[15] fill.
REQ-018 SHALL compute ROR as src rotated right by amt (bit i of result = src[(i+amt) mod 16]).
REQ-019 SHALL pass src unchanged for op 11, and for any op when amt = 0.
REQ-020 SHALL compute Z = (result == 0) and N = result[15] at capture time and store them with the entry.
REQ-021 SHALL hold results in a two-entry buffer: a main entry, which drives the outputs, and a skid entry.
REQ-022 SHALL capture an operation on an edge where in_valid & in_ready & !flush; the result appears on the outputs the next cycle (latency 1).
REQ-023 SHALL drive in_ready = !skid_valid, a function of registered state only with no combinational path from out_ready.
REQ-024 SHALL pop the main entry on an edge where out_valid & out_ready.
REQ-025 SHALL fill the main entry when it is empty or popping; otherwise the capture goes to the skid entry.
REQ-026 SHALL move the skid entry into main when main pops; a simultaneous capture then fills the vacated skid entry.
REQ-027 SHALL sustain one operation per cycle while out_ready stays high.
REQ-028 SHALL hold out_result, out_dst, out_z and out_n stable while out_valid & !out_ready.
REQ-029 SHALL, on flush, clear both entries at that edge and drop that cycle's input; out_valid = 0 and in_ready = 1 on the next cycle.
REQ-030 SHALL give flush priority over a simultaneous capture and pop.
REQ-031 SHALL preserve order: results leave in acceptance order, and none is duplicated or lost.

Reset
REQ-032 SHALL, while rst_n = 0, immediately force out_valid = 0, out_result = 0, out_dst = 0, out_z = 0, out_n = 0, and clear both entries.
REQ-033 SHALL drive in_ready = 1 during and after reset, and discard any operation in flight when reset asserts.

Verification
REQ-034 SHALL pass this directed test: ROR src=16'h8001, amt=1, dst=3, out_ready=1 -> next cycle out_valid=1, out_result=16'hC000, out_dst=3, out_n=1, out_z=0.
REQ-035 SHALL pass this directed test: SRA src=16'h8000 amt=15 -> 16'hFFFF with N=1; SLL src=16'h0001 amt=15 -> 16'h8000; SLL src=16'h8000 amt=1 -> 16'h0000 with Z=1.
REQ-036 SHALL pass this directed test: out_ready=0 and three back-to-back valid ops A, B, C -> A and B accepted, in_ready=0 at C; C held off; then out_ready=1 -> A, B, C emitted in order on consecutive cycles.
REQ-037 SHALL pass this directed test: both entries full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle op never appears.
REQ-038 SHALL pass this directed test: rst_n dropped mid-stream between clock edges -> outputs go to zero immediately without a clock edge; the first op after release has latency 1.
REQ-039 SHALL pass this directed test: 1000 random op/src/amt values with random out_ready -> every output matches a reference model in order, and outputs are stable while stalled.
